// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if
//   Bundles the requester command bus, the shared logic-unit port pair and the
//   response channel of logic_unit_arbiter.
//   Requester side : req_valid, req_ready, req_a, req_b, req_sel (packed per requester)
//   Logic unit side: lu_a, lu_b, lu_select (to unit), lu_out, lu_valid (from unit)
//   Response side  : rsp_valid, rsp_ready, rsp_data, rsp_err, rsp_id
//   Modports: slave  = the arbiter
//             master = everything around it (requesters, logic unit, response sink)
interface logic_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*3-1:0]      req_sel;
  logic [DATA_W-1:0]         lu_a;
  logic [DATA_W-1:0]         lu_b;
  logic [2:0]                lu_select;
  logic [DATA_W-1:0]         lu_out;
  logic                      lu_valid;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [ID_W-1:0]           rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, lu_out, lu_valid, rsp_ready,
    output req_ready, lu_a, lu_b, lu_select, rsp_valid, rsp_data, rsp_err, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, lu_out, lu_valid, rsp_ready,
    input  req_ready, lu_a, lu_b, lu_select, rsp_valid, rsp_data, rsp_err, rsp_id
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one combinational 8-bit logic unit among NUM_REQ requesters with
//   round-robin arbitration. One command in flight: IDLE -> EXEC -> RESP -> IDLE.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : logic_unit_arbiter_if.slave (requester commands, logic unit drive and
//          return, response channel with requester id)
// Optional feature:
//   LU_PRECHECK_EN - when defined, unsupported selects are rejected in IDLE and
//   go straight to RESP with rsp_err=1, leaving lu_* untouched.
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input logic                   clk,
  input logic                   rst,
  logic_unit_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [ID_W-1:0]   id_q;

  logic              found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] g_a;
  logic [DATA_W-1:0] g_b;
  logic [2:0]        g_sel;
  logic              reject;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [PTR_W-1:0] cand;
      cand = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign g_a   = bus.req_a[32'(gnt_idx)*DATA_W +: DATA_W];
  assign g_b   = bus.req_b[32'(gnt_idx)*DATA_W +: DATA_W];
  assign g_sel = bus.req_sel[32'(gnt_idx)*3 +: 3];

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && found)
      bus.req_ready[gnt_idx] = 1'b1;
  end

`ifdef LU_PRECHECK_EN
  function automatic logic sel_ok(input logic [2:0] s);
    case (s)
      3'b000, 3'b100, 3'b010, 3'b001, 3'b110: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction
  assign reject = ~sel_ok(g_sel);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      id_q          <= '0;
      bus.lu_a      <= '0;
      bus.lu_b      <= '0;
      bus.lu_select <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // In IDLE a found grant is exactly the valid&ready handshake.
          if (found) begin
            rr_ptr <= PTR_W'((32'(gnt_idx) + 1) % NUM_REQ);
            id_q   <= ID_W'(gnt_idx);
            if (reject) begin
              // Rejected op bypasses EXEC; lu_* keep their previous value.
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= '0;
              bus.rsp_err   <= 1'b1;
              bus.rsp_id    <= ID_W'(gnt_idx);
              state         <= RESP;
            end else begin
              bus.lu_a      <= g_a;
              bus.lu_b      <= g_b;
              bus.lu_select <= g_sel;
              state         <= EXEC;
            end
          end
        end
        EXEC: begin
          bus.rsp_data  <= bus.lu_valid ? bus.lu_out : '0;
          bus.rsp_err   <= ~bus.lu_valid;
          bus.rsp_id    <= id_q;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
